seq_b2_divider: RTL
===================

Name: seq_b2_divider

Overview:
- Sequential, handshaked radix-2 divider: 2N-bit dividend x by N-bit divisor y, giving N-bit quotient q, N-bit remainder r and flag no_div.
- Generalises the 4-by-2 combinational divider to any N by iterating one 3-by-2-style restoring step per clock.
- Sits between the operand producer and the result consumer, with a valid/ready handshake on each side.
- Same feasibility rule as the combinational divider: division is feasible only if y != 0 and x < y * 2^N.

Parameters:
- N, 2, divisor/quotient/remainder width in bits; dividend width is 2N; legal N >= 2.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer presents x, y
- in_ready  out  1  block can accept operands
- x  in  2N  dividend
- y  in  N  divisor
- out_valid  out  1  q, r, no_div valid
- out_ready  in  1  consumer accepts result
- q  out  N  quotient
- r  out  N  remainder
- no_div  out  1  1 = division infeasible (y == 0 or x >= y * 2^N)

Behaviour:
- Reset: synchronous, active-high; wins over every other event.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, q=0, r=0, no_div=0.
  - Internal registers cleared; any operation in flight is discarded without a result.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, latch x into a 2N-bit shift register and y into the divisor register; next state CHECK. in_valid is ignored in all other states.
  - CHECK: nd = (y == 0) | (x[2N-1:N] >= y), registered as no_div. Remainder register R <= x[2N-1:N]; step counter <= 0; next state STEP.
  - STEP, one quotient bit per cycle, MSB first:
    - T = {R, next dividend bit}, N+1 bits wide.
    - If T >= y: q bit = 1, R <= T - y. Else: q bit = 0, R <= T[N-1:0].
    - Counter increments; after N steps, next state DONE.
    - The invariant R < y holds whenever the division is feasible, so R always fits in N bits.
    - If nd=1 the steps still run, but their values are discarded.
  - DONE: out_valid=1. q holds the quotient and r holds R, or both are 0 if no_div=1. On out_valid & out_ready, next state IDLE and out_valid drops on the same edge.
- Latency and throughput:
  - First out_valid is seen N+2 rising edges after the accept edge: the CHECK edge, N STEP edges, then the DONE edge. N=2 gives 4 edges.
  - One operation in flight; in_ready=0 from accept until the DONE handshake completes.
- Backpressure: while out_valid=1 and out_ready=0, q, r and no_div are held constant.
- Output stability: q, r and no_div change only on the edge entering DONE or on reset; they keep their old values between operations.
- Arithmetic: unsigned. Comparisons and subtraction use N+1-bit width, no truncation before compare.
- Boundaries:
  - x=0 with y!=0 gives q=0, r=0.
  - x[2N-1:N] == y-1 is feasible, e.g. the maximum quotient 2^N - 1.
  - y==0 always sets no_div=1, whatever x is.

Optional Feature:
- Macro: SEQ_B2_DIVIDER_EARLY_NO_DIV_EN.
- Defined: CHECK goes directly to DONE when nd=1, skipping STEP. An infeasible result has out_valid 2 edges after accept, with q=0 and r=0.
- Undefined: latency is always N+2 edges, independent of the data (constant-time behaviour).

Test Plan:
- N=2, x=4'b1011 (11), y=2'b11 (3), out_ready=1 → after 4 edges: out_valid=1, q=2'b11, r=2'b10, no_div=0; in_ready=1 on the next cycle.
- N=2, x=4'b1101, y=2'b10 (upper bits 11 >= 10) → no_div=1, q=0, r=0. Latency is 4 edges without the macro and 2 edges with it.
- N=2, y=2'b00, x=4'b0001 → no_div=1, q=0, r=0; then a back-to-back operation x=4'b0110, y=2'b11 → q=2'b10, r=2'b00.
- N=4, x=8'hC8 (200), y=4'hF → q=4'hD, r=4'h5. Hold out_ready=0 for 5 cycles: outputs stay stable and in_ready=0. When out_ready=1, the handshake completes on one edge.
- N=2, assert reset during STEP → next edge: IDLE, out_valid=0, q=r=0, no_div=0. The aborted operation never produces out_valid. A new operation x=4'b0111, y=2'b10 gives q=2'b11, r=2'b01.
- in_valid pulsed while busy with different operands → ignored; the result matches the first accepted operands only.

Source files
------------

// File: rtl/seq_b2_divider_if.sv
// seq_b2_divider_if: operand/result handshake bundle for the sequential radix-2 divider.
// master = operand producer / result consumer side, slave = divider side.
interface seq_b2_divider_if #(
  parameter int N = 2
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] x;
  logic [N-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   q;
  logic [N-1:0]   r;
  logic           no_div;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, q, r, no_div
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, q, r, no_div
  );
endinterface

// File: rtl/seq_b2_divider.sv
// seq_b2_divider: sequential restoring divider, 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
// Optional macro SEQ_B2_DIVIDER_EARLY_NO_DIV_EN: an infeasible division skips the
// step phase and reports early; without it latency is data-independent (N+2 edges).
module seq_b2_divider #(
  parameter int N = 2
) (
  input logic             clock,
  input logic             reset,
  seq_b2_divider_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_STEP  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [2*N-1:0] x_q, x_d;           // dividend shift register, next bit at [N-1]
  logic [N-1:0]   y_q, y_d;           // divisor
  logic [N-1:0]   rem_q, rem_d;       // partial remainder R
  logic [N-1:0]   quo_q, quo_d;       // quotient bits collected MSB first
  logic [CW-1:0]  cnt_q, cnt_d;       // completed step count
  logic           nd_q, nd_d;         // infeasibility captured in CHECK
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic           no_div_q, no_div_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;

  logic [N:0]     trial_s;
  logic           ge_s;
  logic [N-1:0]   diff_s;
  logic [N-1:0]   rem_step_s;
  logic [N-1:0]   quo_step_s;
  logic           nd_chk_s;
  logic           last_step_s;
  logic           accept_s;
  logic           release_s;

  // Restoring step datapath: trial value, compare and subtract at N+1 bits.
  always_comb begin
    trial_s     = {rem_q, x_q[N-1]};
    ge_s        = (trial_s >= {1'b0, y_q});
    // Low N bits of the N+1-bit difference; the result is < y whenever feasible.
    diff_s      = trial_s[N-1:0] - y_q;
    rem_step_s  = ge_s ? diff_s : trial_s[N-1:0];
    quo_step_s  = {quo_q[N-2:0], ge_s};
    nd_chk_s    = (y_q == {N{1'b0}}) | (x_q[2*N-1:N] >= y_q);
    last_step_s = (cnt_q == CW'(N - 1));
    accept_s    = bus.in_valid & in_ready_q;
    release_s   = out_valid_q & bus.out_ready;
  end

  // State and datapath registers with synchronous reset that discards any operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= {(2*N){1'b0}};
      y_q         <= {N{1'b0}};
      rem_q       <= {N{1'b0}};
      quo_q       <= {N{1'b0}};
      cnt_q       <= {CW{1'b0}};
      nd_q        <= 1'b0;
      q_q         <= {N{1'b0}};
      r_q         <= {N{1'b0}};
      no_div_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      nd_q        <= nd_d;
      q_q         <= q_d;
      r_q         <= r_d;
      no_div_q    <= no_div_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_CHECK;
        else          state_d = S_IDLE;
      end
      S_CHECK: begin
`ifdef SEQ_B2_DIVIDER_EARLY_NO_DIV_EN
        if (nd_chk_s) state_d = S_DONE;
        else          state_d = S_STEP;
`else
        state_d = S_STEP;
`endif
      end
      S_STEP: begin
        if (last_step_s) state_d = S_DONE;
        else             state_d = S_STEP;
      end
      S_DONE: begin
        if (release_s) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state register updates and registered handshake outputs.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    nd_d        = nd_q;
    q_d         = q_q;
    r_d         = r_q;
    no_div_d    = no_div_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          x_d = bus.x;
          y_d = bus.y;
        end else begin
          x_d = x_q;
          y_d = y_q;
        end
      end
      S_CHECK: begin
        nd_d  = nd_chk_s;
        rem_d = x_q[2*N-1:N];
        quo_d = {N{1'b0}};
        cnt_d = {CW{1'b0}};
      end
      S_STEP: begin
        // Steps run even when infeasible so latency stays constant; DONE masks them.
        rem_d = rem_step_s;
        quo_d = quo_step_s;
        x_d   = {x_q[2*N-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
      end
      S_DONE: begin
        // First DONE cycle publishes the result; after that it is held until taken.
        if (!out_valid_q) begin
          q_d         = nd_q ? {N{1'b0}} : quo_q;
          r_d         = nd_q ? {N{1'b0}} : rem_q;
          no_div_d    = nd_q;
          out_valid_d = 1'b1;
        end else if (release_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.no_div    = no_div_q;

endmodule
